// File: rtl/tk1_spi_flash_reader.sv
// SPI flash read sequencer: issues opcode + 24-bit address, then clocks out
// dummy bytes and streams each received byte to a valid/ready consumer.
module tk1_spi_flash_reader #(
   parameter logic [7:0] READ_OPCODE = 8'h03,
   parameter logic [7:0] DUMMY_TX    = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_start,
   input  logic [23:0] cmd_addr,
   input  logic [15:0] cmd_len,
   input  logic        cmd_abort,
   output logic        busy,
   output logic        done,
   output logic        aborted,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        spi_enable,
   output logic        spi_enable_vld,
   output logic [7:0]  spi_tx_data,
   output logic        spi_tx_data_vld,
   output logic        spi_start,
   input  logic        spi_ready,
   input  logic [7:0]  spi_rx_data
);

   localparam int unsigned ADDR_W = 24;
   localparam int unsigned LEN_W  = 16;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned BYTE_W = 8;
   localparam logic [IDX_W-1:0] IDX_DATA = IDX_W'(4);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CS_ON  = 3'd1,
      LOAD   = 3'd2,
      XFER   = 3'd3,
      WAIT   = 3'd4,
      PUSH   = 3'd5,
      CS_OFF = 3'd6
   } state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   addr_q, addr_nxt;
   logic [LEN_W-1:0]    remain_q, remain_nxt;
   logic [IDX_W-1:0]    idx_q, idx_nxt;
   logic                abort_q, abort_nxt;
   logic                wait_first_q, wait_first_nxt;

   logic                busy_nxt, done_nxt, aborted_nxt;
   logic [BYTE_W-1:0]   rx_data_nxt;
   logic                rx_valid_nxt;
   logic                spi_enable_nxt, spi_enable_vld_nxt;
   logic [BYTE_W-1:0]   spi_tx_data_nxt;
   logic                spi_tx_data_vld_nxt, spi_start_nxt;

   // Command phase bytes by index; anything past the address is a dummy clock-out.
   function automatic logic [BYTE_W-1:0] cmd_byte(input logic [IDX_W-1:0] idx,
                                                  input logic [ADDR_W-1:0] addr);
      case (idx)
         IDX_W'(0): cmd_byte = READ_OPCODE;
         IDX_W'(1): cmd_byte = addr[23:16];
         IDX_W'(2): cmd_byte = addr[15:8];
         IDX_W'(3): cmd_byte = addr[7:0];
         default:   cmd_byte = DUMMY_TX;
      endcase
   endfunction

   // Registers: state, sequence context and every output.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         addr_q          <= '0;
         remain_q        <= '0;
         idx_q           <= '0;
         abort_q         <= 1'b0;
         wait_first_q    <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         aborted         <= 1'b0;
         rx_data         <= '0;
         rx_valid        <= 1'b0;
         spi_enable      <= 1'b0;
         spi_enable_vld  <= 1'b0;
         spi_tx_data     <= '0;
         spi_tx_data_vld <= 1'b0;
         spi_start       <= 1'b0;
      end else begin
         state           <= state_nxt;
         addr_q          <= addr_nxt;
         remain_q        <= remain_nxt;
         idx_q           <= idx_nxt;
         abort_q         <= abort_nxt;
         wait_first_q    <= wait_first_nxt;
         busy            <= busy_nxt;
         done            <= done_nxt;
         aborted         <= aborted_nxt;
         rx_data         <= rx_data_nxt;
         rx_valid        <= rx_valid_nxt;
         spi_enable      <= spi_enable_nxt;
         spi_enable_vld  <= spi_enable_vld_nxt;
         spi_tx_data     <= spi_tx_data_nxt;
         spi_tx_data_vld <= spi_tx_data_vld_nxt;
         spi_start       <= spi_start_nxt;
      end
   end

   // Next-state and next-output logic; outputs are decoded from the next state
   // so each strobe is high exactly while the FSM sits in its state.
   always_comb begin
      state_nxt      = state;
      addr_nxt       = addr_q;
      remain_nxt     = remain_q;
      idx_nxt        = idx_q;
      abort_nxt      = abort_q;
      wait_first_nxt = 1'b0;
      rx_data_nxt    = rx_data;
      done_nxt       = 1'b0;
      aborted_nxt    = 1'b0;

      case (state)
         IDLE: begin
            abort_nxt = 1'b0;
            if (cmd_start) begin
               if (cmd_len != LEN_W'(0)) begin
                  addr_nxt   = cmd_addr;
                  remain_nxt = cmd_len;
                  idx_nxt    = '0;
                  state_nxt  = CS_ON;
               end else begin
                  done_nxt = 1'b1;
               end
            end
         end

         CS_ON: begin
            state_nxt = LOAD;
         end

         LOAD: begin
            state_nxt = XFER;
         end

         XFER: begin
            state_nxt      = WAIT;
            wait_first_nxt = 1'b1;
         end

         WAIT: begin
            if (cmd_abort) begin
               abort_nxt = 1'b1;
            end
            // First WAIT cycle is skipped: the master has not yet dropped ready.
            if (spi_ready && !wait_first_q) begin
               if (abort_q || cmd_abort) begin
                  state_nxt = CS_OFF;
               end else if (idx_q < IDX_DATA) begin
                  idx_nxt   = idx_q + IDX_W'(1);
                  state_nxt = LOAD;
               end else begin
                  rx_data_nxt = spi_rx_data;
                  state_nxt   = PUSH;
               end
            end
         end

         PUSH: begin
            if (rx_ready) begin
               remain_nxt = remain_q - LEN_W'(1);
               idx_nxt    = (idx_q < IDX_DATA) ? idx_q + IDX_W'(1) : idx_q;
               state_nxt  = (remain_q == LEN_W'(1)) ? CS_OFF : LOAD;
            end
         end

         CS_OFF: begin
            state_nxt   = IDLE;
            done_nxt    = !abort_q;
            aborted_nxt = abort_q;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Abort outside WAIT closes the sequence on the next cycle.
      if (cmd_abort && (state == CS_ON || state == LOAD ||
                        state == XFER  || state == PUSH)) begin
         abort_nxt = 1'b1;
         state_nxt = CS_OFF;
         remain_nxt = remain_q;
         idx_nxt    = idx_q;
      end

      busy_nxt            = (state_nxt != IDLE);
      rx_valid_nxt        = (state_nxt == PUSH);
      spi_enable_vld_nxt  = (state_nxt == CS_ON) || (state_nxt == CS_OFF);
      spi_tx_data_vld_nxt = (state_nxt == LOAD);
      spi_start_nxt       = (state_nxt == XFER);

      spi_enable_nxt = spi_enable;
      if (state_nxt == CS_ON) begin
         spi_enable_nxt = 1'b1;
      end else if (state_nxt == CS_OFF) begin
         spi_enable_nxt = 1'b0;
      end

      spi_tx_data_nxt = spi_tx_data;
      if (state_nxt == LOAD) begin
         spi_tx_data_nxt = cmd_byte(idx_nxt, addr_nxt);
      end
   end

endmodule

// File: tb/tb_tk1_spi_flash_reader.sv
// Directed bench for tk1_spi_flash_reader with a small behavioural SPI master.
module tb_tk1_spi_flash_reader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_start = 1'b0;
   logic [23:0] cmd_addr = '0;
   logic [15:0] cmd_len = '0;
   logic        cmd_abort = 1'b0;
   logic        busy, done, aborted;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready = 1'b0;
   logic        spi_enable, spi_enable_vld;
   logic [7:0]  spi_tx_data;
   logic        spi_tx_data_vld, spi_start;
   logic        spi_ready = 1'b1;
   logic [7:0]  spi_rx_data = '0;

   int n_vec = 0;
   int n_err = 0;

   tk1_spi_flash_reader dut (
      .clk(clk), .reset(reset),
      .cmd_start(cmd_start), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_abort(cmd_abort),
      .busy(busy), .done(done), .aborted(aborted),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .spi_enable(spi_enable), .spi_enable_vld(spi_enable_vld),
      .spi_tx_data(spi_tx_data), .spi_tx_data_vld(spi_tx_data_vld),
      .spi_start(spi_start), .spi_ready(spi_ready), .spi_rx_data(spi_rx_data)
   );

   always #5 clk = ~clk;

   // SPI master model: ready drops after a start, returns after two cycles.
   logic [7:0] data_mem [8];
   logic [7:0] pend = '0;
   int         busy_cnt = 0;
   int         xi = 0;

   always @(negedge clk) begin
      if (reset) begin
         spi_ready = 1'b1;
         busy_cnt  = 0;
         xi        = 0;
      end else begin
         if (spi_enable_vld && spi_enable) xi = 0;
         if (spi_start) begin
            spi_ready = 1'b0;
            busy_cnt  = 2;
            pend      = (xi >= 4) ? data_mem[(xi - 4) % 8] : 8'hEE;
            xi++;
         end else if (busy_cnt != 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
               spi_ready   = 1'b1;
               spi_rx_data = pend;
            end
         end
      end
   end

   // Monitor: logs bytes, strobes and pulses mid-cycle.
   logic [7:0] tx_log [$];
   logic [7:0] rx_log [$];
   logic       en_log [$];
   int n_start = 0, n_done = 0, n_abort = 0, n_excl = 0;

   always @(negedge clk) begin
      if (!reset) begin
         if (spi_tx_data_vld) tx_log.push_back(spi_tx_data);
         if (spi_enable_vld)  en_log.push_back(spi_enable);
         if (spi_start)       n_start++;
         if (rx_valid && rx_ready) rx_log.push_back(rx_data);
         if (done)            n_done++;
         if (aborted)         n_abort++;
         if ((32'(spi_enable_vld) + 32'(spi_tx_data_vld) + 32'(spi_start)) > 1) n_excl++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_end(input string tag, input int budget);
      bit hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         if (done || aborted) hit = 1'b1;
      end
      chk({tag, "_end"}, 64'(hit), 64'd1);
   endtask

   task automatic wait_rx(input string tag, input int budget);
      bit hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         if (rx_valid) hit = 1'b1;
      end
      chk({tag, "_rxv"}, 64'(hit), 64'd1);
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({busy, done, aborted, rx_valid, rx_data, spi_enable, spi_enable_vld,
                  spi_tx_data, spi_tx_data_vld, spi_start});
   endfunction

   initial begin
      int tb0, rb0, eb0, db0, ab0, sb0, k;
      logic [7:0] exp_a [6];
      logic [7:0] exp_c [7];
      logic [7:0] exp_d [3];

      // Reset values
      repeat (3) step();
      chk("reset_outs", all_outs(), 64'd0);
      reset = 1'b0;
      step();
      chk("idle_outs", all_outs(), 64'd0);

      // A: two-byte read, consumer always ready
      exp_a = '{8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00};
      data_mem[0] = 8'hA5;
      data_mem[1] = 8'h5A;
      tb0 = tx_log.size(); rb0 = rx_log.size(); eb0 = en_log.size();
      db0 = n_done; ab0 = n_abort;
      cmd_addr = 24'h012345; cmd_len = 16'd2; rx_ready = 1'b1; cmd_start = 1'b1;
      step();
      cmd_start = 1'b0;
      chk("A_cs_on", 64'({busy, spi_enable_vld, spi_enable}), 64'b111);
      wait_end("A", 400);
      step();
      chk("A_done_width", 64'(done), 64'd0);
      chk("A_busy_after", 64'(busy), 64'd0);
      chk("A_ntx", 64'(tx_log.size() - tb0), 64'd6);
      for (int i = 0; i < 6; i++) chk($sformatf("A_tx%0d", i), 64'(tx_log[tb0 + i]), 64'(exp_a[i]));
      chk("A_nrx", 64'(rx_log.size() - rb0), 64'd2);
      chk("A_rx0", 64'(rx_log[rb0]), 64'hA5);
      chk("A_rx1", 64'(rx_log[rb0 + 1]), 64'h5A);
      chk("A_en", 64'({en_log.size() - eb0 == 2, en_log[eb0], en_log[eb0 + 1]}), 64'b110);
      chk("A_ndone", 64'(n_done - db0), 64'd1);
      chk("A_nabort", 64'(n_abort - ab0), 64'd0);

      // B: zero-length command completes at once, no SPI activity
      eb0 = en_log.size(); sb0 = n_start; tb0 = tx_log.size();
      cmd_len = 16'd0; cmd_start = 1'b1;
      step();
      cmd_start = 1'b0;
      chk("B_done", 64'({done, busy}), 64'b10);
      step();
      chk("B_done_width", 64'(done), 64'd0);
      repeat (4) step();
      chk("B_no_spi", 64'({en_log.size() - eb0, n_start - sb0, tx_log.size() - tb0}), 64'd0);

      // C: consumer stalls on byte 1; restart during busy must be ignored
      exp_c = '{8'h03, 8'h00, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00};
      data_mem[0] = 8'h11; data_mem[1] = 8'h22; data_mem[2] = 8'h33;
      tb0 = tx_log.size(); rb0 = rx_log.size(); db0 = n_done;
      cmd_addr = 24'h00ABCD; cmd_len = 16'd3; rx_ready = 1'b0; cmd_start = 1'b1;
      step();
      cmd_start = 1'b0;
      wait_rx("C", 200);
      sb0 = n_start;
      for (int i = 0; i < 10; i++) begin
         step();
         cmd_start = (i == 3);
         if (i == 3) begin
            cmd_addr = 24'hFFFFFF;
            cmd_len  = 16'd5;
         end
         chk($sformatf("C_stall%0d", i), 64'({rx_valid, rx_data}), 64'({1'b1, 8'h11}));
      end
      cmd_start = 1'b0;
      chk("C_no_start", 64'(n_start - sb0), 64'd0);
      rx_ready = 1'b1;
      wait_end("C", 400);
      step();
      chk("C_ntx", 64'(tx_log.size() - tb0), 64'd7);
      for (int i = 0; i < 7; i++) chk($sformatf("C_tx%0d", i), 64'(tx_log[tb0 + i]), 64'(exp_c[i]));
      chk("C_nrx", 64'(rx_log.size() - rb0), 64'd3);
      chk("C_rx", 64'({rx_log[rb0], rx_log[rb0 + 1], rx_log[rb0 + 2]}), 64'h112233);
      chk("C_ndone", 64'(n_done - db0), 64'd1);

      // D: abort while waiting on the second address byte
      exp_d = '{8'h03, 8'h10, 8'h20};
      tb0 = tx_log.size(); rb0 = rx_log.size(); eb0 = en_log.size();
      db0 = n_done; ab0 = n_abort; sb0 = n_start;
      cmd_addr = 24'h102030; cmd_len = 16'd4; rx_ready = 1'b1; cmd_start = 1'b1;
      step();
      cmd_start = 1'b0;
      k = 0;
      for (int i = 0; i < 300 && k < 3; i++) begin
         @(negedge clk);
         if (spi_start) k++;
      end
      chk("D_third_start", 64'(k), 64'd3);
      step();
      cmd_abort = 1'b1;
      step();
      cmd_abort = 1'b0;
      wait_end("D", 200);
      step();
      chk("D_nabort", 64'(n_abort - ab0), 64'd1);
      chk("D_ndone", 64'(n_done - db0), 64'd0);
      chk("D_nrx", 64'(rx_log.size() - rb0), 64'd0);
      chk("D_nstart", 64'(n_start - sb0), 64'd3);
      chk("D_ntx", 64'(tx_log.size() - tb0), 64'd3);
      for (int i = 0; i < 3; i++) chk($sformatf("D_tx%0d", i), 64'(tx_log[tb0 + i]), 64'(exp_d[i]));
      chk("D_en", 64'({en_log.size() - eb0 == 2, en_log[eb0], en_log[eb0 + 1]}), 64'b110);
      chk("D_aborted_width", 64'({aborted, busy}), 64'd0);

      // E: start and abort together (start wins), then reset while in PUSH
      data_mem[0] = 8'h77;
      cmd_addr = 24'h0000FF; cmd_len = 16'd2; rx_ready = 1'b0;
      cmd_start = 1'b1; cmd_abort = 1'b1;
      step();
      cmd_start = 1'b0; cmd_abort = 1'b0;
      chk("E_start_wins", 64'({busy, spi_enable_vld, spi_enable}), 64'b111);
      wait_rx("E", 200);
      chk("E_rx_data", 64'(rx_data), 64'h77);
      step();
      eb0 = en_log.size();
      reset = 1'b1;
      step();
      chk("E_reset_outs", all_outs(), 64'd0);
      reset = 1'b0;
      repeat (4) step();
      chk("E_no_cs_off", 64'(en_log.size() - eb0), 64'd0);
      chk("E_idle", all_outs(), 64'd0);

      // F: abort in IDLE has no effect
      ab0 = n_abort;
      cmd_abort = 1'b1;
      step();
      cmd_abort = 1'b0;
      repeat (4) step();
      chk("F_abort_idle", 64'({n_abort - ab0 != 0, busy}), 64'd0);

      chk("strobe_exclusive", 64'(n_excl), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
